acc_slv_adapter: RTL and testbench
==================================

ACC_SLV_ADAPTER -- requirements
Module: acc_slv_adapter

Interface
REQ-001 SHALL have parameter DataWidth, default 32: operand/result width.
REQ-002 SHALL have parameter IdWidth, default 4: extended request ID width as produced by the interconnect slave port.
REQ-003 SHALL have parameter Depth, default 4: maximum outstanding requests, power of two, at least 2.
REQ-004 SHALL have one clock and an asynchronous active-low reset, as listed in the port table below.
REQ-005 SHALL have the following ports, clock and reset first (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- slv_q_valid_i  in  1  request valid from interconnect
- slv_q_ready_o  out  1  request ready to interconnect
- slv_q_data_op_i  in  32  instruction word
- slv_q_data_arga_i  in  DataWidth  operand A
- slv_q_id_i  in  IdWidth  request ID
- slv_p_valid_o  out  1  response valid to interconnect
- slv_p_ready_i  in  1  response ready from interconnect
- slv_p_data_o  out  DataWidth  result
- slv_p_id_o  out  IdWidth  ID of the request answered
- acc_q_valid_o  out  1  request valid to accelerator core
- acc_q_ready_i  in  1  core accepts request
- acc_q_data_op_o  out  32  instruction word
- acc_q_data_arga_o  out  DataWidth  operand A
- acc_p_valid_i  in  1  core result valid, in request order
- acc_p_ready_o  out  1  adapter accepts result
- acc_p_data_i  in  DataWidth  core result
- outstanding_o  out  $clog2(Depth+1)  in-flight count
- err_o  out  1  sticky protocol error

Function
REQ-006 SHALL forward requests combinationally: acc_q_valid_o = slv_q_valid_i & ~full; slv_q_ready_o = acc_q_ready_i & ~full; data passes through unchanged.
REQ-007 SHALL push slv_q_id_i into an in-order ID FIFO on each request handshake (acc_q_valid_o & acc_q_ready_i).
REQ-008 SHALL assert full when outstanding_o == Depth; a pop in the same cycle SHALL NOT unblock a push (no bypass).
REQ-009 SHALL pop the FIFO head on each core-result handshake (acc_p_valid_i & acc_p_ready_o); slv_p_id_o SHALL equal the popped ID.
REQ-010 SHALL update outstanding_o each cycle as +1 on push, -1 on pop, and unchanged when both or neither occur.
REQ-011 SHALL treat the response path as unregistered when the macro in REQ-017 is absent: slv_p_valid_o = acc_p_valid_i & ~empty; acc_p_ready_o = slv_p_ready_i | empty; slv_p_data_o = acc_p_data_i.
REQ-012 SHALL, on acc_p_valid_i while the FIFO is empty, accept and drop the result, not pop, and set err_o.
REQ-013 SHALL wrap the FIFO read and write pointers modulo Depth; a push and a pop in the same cycle SHALL be legal when neither full nor empty.
REQ-014 SHALL hold slv_p_valid_o, slv_p_data_o and slv_p_id_o stable until slv_p_ready_i once valid is asserted.

Reset
REQ-015 SHALL, while rst_ni is low, clear the pointers, outstanding_o, err_o and any response register, and drive slv_p_valid_o=0, acc_q_valid_o=0, slv_q_ready_o=0, slv_p_id_o=0 and slv_p_data_o=0.
REQ-016 SHALL, when reset is asserted mid-operation, discard all in-flight IDs; the first request after release SHALL be handled as if the adapter were empty.

Configuration
REQ-017 SHALL, when ACC_ADAPTER_RSP_REG_EN is defined, insert a one-entry response register: pop and ID capture occur at the core-side handshake; slv_p_valid_o is driven from the register (one-cycle latency); acc_p_ready_o = ~reg_valid | slv_p_ready_i, permitting full throughput.
REQ-018 SHALL, when ACC_ADAPTER_RSP_REG_EN is undefined, have the response path fully combinational per REQ-011.

Structure
REQ-019 SHALL place the shared request/response struct typedefs and the default Depth constant in acc_pkg.
REQ-020 SHALL implement the ID FIFO as sub-module acc_id_fifo (push, pop, full, empty, count).

Verification
REQ-021 SHALL cover single transaction: ID 0x5 request, core returns 0xCAFE -> slv_p_id_o=0x5, slv_p_data_o=0xCAFE, outstanding_o returns to 0.
REQ-022 SHALL cover saturation: 4 requests with IDs 1,2,3,4 and the core stalled -> 5th request sees slv_q_ready_o=0 and outstanding_o=4; responses return IDs in order 1,2,3,4.
REQ-023 SHALL cover simultaneous traffic at full: outstanding_o=4 with push and pop offered in the same cycle -> pop only, outstanding_o=3, push accepted the next cycle.
REQ-024 SHALL cover orphan response: acc_p_valid_i with the FIFO empty -> slv_p_valid_o stays 0 and err_o=1 until reset.
REQ-025 SHALL cover backpressure: slv_p_ready_i held low for 3 cycles -> response signals stable, acc_p_ready_o=0 (registered variant: first result held and second core result stalled).
REQ-026 SHALL cover mid-operation reset: reset asserted with 2 outstanding -> after release outstanding_o=0, err_o=0, and a new ID 0x7 returns correctly.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and defaults for the accelerator slave adapter and its ID FIFO.
package acc_pkg;

  localparam int unsigned DefaultDepth     = 4;
  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultIdWidth   = 4;

  typedef struct packed {
    logic [31:0]                 op;
    logic [DefaultDataWidth-1:0] arga;
    logic [DefaultIdWidth-1:0]   id;
  } acc_req_t;

  typedef struct packed {
    logic [DefaultDataWidth-1:0] data;
    logic [DefaultIdWidth-1:0]   id;
  } acc_rsp_t;

  typedef enum logic [1:0] {
    FifoIdle = 2'b00,
    FifoPush = 2'b01,
    FifoPop  = 2'b10,
    FifoBoth = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/acc_id_fifo.sv
// In-order FIFO of request IDs awaiting a core result; pointers wrap modulo Depth.
module acc_id_fifo
  import acc_pkg::*;
#(
  parameter int unsigned Depth   = DefaultDepth,
  parameter int unsigned IdWidth = DefaultIdWidth
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [IdWidth-1:0]         id_i,
  input  logic                       pop_i,
  output logic [IdWidth-1:0]         id_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  logic [IdWidth-1:0] mem_q [Depth];
  logic [IdWidth-1:0] mem_d [Depth];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign id_o    = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = id_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    unique case (fifo_op(do_push, do_pop))
      FifoPush: count_d = count_q + CntW'(1);
      FifoPop:  count_d = count_q - CntW'(1);
      default:  count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/acc_slv_adapter.sv
// Bridges an interconnect slave port to an in-order accelerator core, restoring request IDs.
// Defining ACC_ADAPTER_RSP_REG_EN adds a one-entry response register on the result path.
module acc_slv_adapter
  import acc_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned Depth     = DefaultDepth
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       slv_q_valid_i,
  output logic                       slv_q_ready_o,
  input  logic [31:0]                slv_q_data_op_i,
  input  logic [DataWidth-1:0]       slv_q_data_arga_i,
  input  logic [IdWidth-1:0]         slv_q_id_i,
  output logic                       slv_p_valid_o,
  input  logic                       slv_p_ready_i,
  output logic [DataWidth-1:0]       slv_p_data_o,
  output logic [IdWidth-1:0]         slv_p_id_o,
  output logic                       acc_q_valid_o,
  input  logic                       acc_q_ready_i,
  output logic [31:0]                acc_q_data_op_o,
  output logic [DataWidth-1:0]       acc_q_data_arga_o,
  input  logic                       acc_p_valid_i,
  output logic                       acc_p_ready_o,
  input  logic [DataWidth-1:0]       acc_p_data_i,
  output logic [$clog2(Depth+1)-1:0] outstanding_o,
  output logic                       err_o
);

  logic               full, empty, push, pop;
  logic [IdWidth-1:0] head_id;
  logic               err_q, err_d;

  // Requests pass straight through; gating with rst_ni keeps handshakes quiet in reset.
  assign acc_q_valid_o     = rst_ni & slv_q_valid_i & ~full;
  assign slv_q_ready_o     = rst_ni & acc_q_ready_i & ~full;
  assign acc_q_data_op_o   = slv_q_data_op_i;
  assign acc_q_data_arga_o = slv_q_data_arga_i;
  assign push              = acc_q_valid_o & acc_q_ready_i;

`ifdef ACC_ADAPTER_RSP_REG_EN
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
  logic [IdWidth-1:0]   rsp_id_q, rsp_id_d;

  assign acc_p_ready_o = ~rsp_valid_q | slv_p_ready_i | empty;
  assign pop           = acc_p_valid_i & acc_p_ready_o & ~empty;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (rsp_valid_q && slv_p_ready_i) begin
      rsp_valid_d = 1'b0;
    end
    if (pop) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = acc_p_data_i;
      rsp_id_d    = head_id;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign slv_p_valid_o = rsp_valid_q;
  assign slv_p_data_o  = rsp_data_q;
  assign slv_p_id_o    = rsp_id_q;
`else
  // An empty FIFO means any core result is an orphan, so it is always accepted and dropped.
  assign acc_p_ready_o = slv_p_ready_i | empty;
  assign pop           = acc_p_valid_i & acc_p_ready_o & ~empty;
  assign slv_p_valid_o = rst_ni & acc_p_valid_i & ~empty;
  assign slv_p_data_o  = rst_ni ? acc_p_data_i : '0;
  assign slv_p_id_o    = rst_ni ? head_id : '0;
`endif

  assign err_d = err_q | (acc_p_valid_i & empty);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

  acc_id_fifo #(
    .Depth  (Depth),
    .IdWidth(IdWidth)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .id_i   (slv_q_id_i),
    .pop_i  (pop),
    .id_o   (head_id),
    .full_o (full),
    .empty_o(empty),
    .count_o(outstanding_o)
  );

endmodule

// File: tb/tb_acc_slv_adapter.sv
// Directed self-checking bench for acc_slv_adapter in its default (unregistered response) build.
module tb_acc_slv_adapter;

  logic        clk;
  logic        rst_ni;
  logic        slv_q_valid_i;
  logic        slv_q_ready_o;
  logic [31:0] slv_q_data_op_i;
  logic [31:0] slv_q_data_arga_i;
  logic [3:0]  slv_q_id_i;
  logic        slv_p_valid_o;
  logic        slv_p_ready_i;
  logic [31:0] slv_p_data_o;
  logic [3:0]  slv_p_id_o;
  logic        acc_q_valid_o;
  logic        acc_q_ready_i;
  logic [31:0] acc_q_data_op_o;
  logic [31:0] acc_q_data_arga_o;
  logic        acc_p_valid_i;
  logic        acc_p_ready_o;
  logic [31:0] acc_p_data_i;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        q_valid;
    logic        acc_q_ready;
    logic [31:0] op;
    logic [31:0] arga;
    logic [3:0]  id;
    logic        p_valid;
    logic        p_ready;
    logic [31:0] p_data;
    logic        e_q_ready;
    logic        e_acc_q_valid;
    logic        e_p_valid;
    logic [3:0]  e_p_id;
    logic [31:0] e_p_data;
    logic        e_acc_p_ready;
    logic [2:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t vecs[8];

  acc_slv_adapter #(
    .DataWidth(32),
    .IdWidth  (4),
    .Depth    (4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .slv_q_valid_i    (slv_q_valid_i),
    .slv_q_ready_o    (slv_q_ready_o),
    .slv_q_data_op_i  (slv_q_data_op_i),
    .slv_q_data_arga_i(slv_q_data_arga_i),
    .slv_q_id_i       (slv_q_id_i),
    .slv_p_valid_o    (slv_p_valid_o),
    .slv_p_ready_i    (slv_p_ready_i),
    .slv_p_data_o     (slv_p_data_o),
    .slv_p_id_o       (slv_p_id_o),
    .acc_q_valid_o    (acc_q_valid_o),
    .acc_q_ready_i    (acc_q_ready_i),
    .acc_q_data_op_o  (acc_q_data_op_o),
    .acc_q_data_arga_o(acc_q_data_arga_o),
    .acc_p_valid_i    (acc_p_valid_i),
    .acc_p_ready_o    (acc_p_ready_o),
    .acc_p_data_i     (acc_p_data_i),
    .outstanding_o    (outstanding_o),
    .err_o            (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    slv_q_valid_i     = v.q_valid;
    acc_q_ready_i     = v.acc_q_ready;
    slv_q_data_op_i   = v.op;
    slv_q_data_arga_i = v.arga;
    slv_q_id_i        = v.id;
    acc_p_valid_i     = v.p_valid;
    slv_p_ready_i     = v.p_ready;
    acc_p_data_i      = v.p_data;
  endtask

  task automatic drive(input logic qv, input logic [3:0] id, input logic pv,
                       input logic pr, input logic [31:0] pd);
    slv_q_valid_i     = qv;
    acc_q_ready_i     = 1'b1;
    slv_q_data_op_i   = 32'h0000_0013;
    slv_q_data_arga_i = {28'h0, id};
    slv_q_id_i        = id;
    acc_p_valid_i     = pv;
    slv_p_ready_i     = pr;
    acc_p_data_i      = pd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_ids [4];
    exp_ids = '{4'h2, 4'h3, 4'h4, 4'h5};

    // Single transaction, a push/pop overlap, and passthrough of op/arga.
    vecs[0] = '{0, 1, 32'h0,  32'h0,  4'h0, 0, 1, 32'h0,      1, 0, 0, 4'h0, 32'h0,      1, 3'd0, 0};
    vecs[1] = '{1, 1, 32'h13, 32'h11, 4'h5, 0, 1, 32'h0,      1, 1, 0, 4'h0, 32'h0,      1, 3'd0, 0};
    vecs[2] = '{0, 1, 32'h0,  32'h0,  4'h0, 1, 1, 32'hCAFE,   1, 0, 1, 4'h5, 32'hCAFE,   1, 3'd1, 0};
    vecs[3] = '{0, 1, 32'h0,  32'h0,  4'h0, 0, 1, 32'h0,      1, 0, 0, 4'h0, 32'h0,      1, 3'd0, 0};
    vecs[4] = '{1, 1, 32'h33, 32'h22, 4'h9, 0, 1, 32'h0,      1, 1, 0, 4'h0, 32'h0,      1, 3'd0, 0};
    vecs[5] = '{1, 1, 32'h53, 32'h44, 4'hA, 1, 1, 32'h1111,   1, 1, 1, 4'h9, 32'h1111,   1, 3'd1, 0};
    vecs[6] = '{0, 1, 32'h0,  32'h0,  4'h0, 1, 1, 32'h2222,   1, 0, 1, 4'hA, 32'h2222,   1, 3'd1, 0};
    vecs[7] = '{0, 1, 32'h0,  32'h0,  4'h0, 0, 1, 32'h0,      1, 0, 0, 4'h0, 32'h0,      1, 3'd0, 0};

    rst_ni = 1'b0;
    drive(1'b1, 4'h3, 1'b1, 1'b1, 32'h55);
    #12;
    checkOutput("rst_outstanding", 32'(outstanding_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    checkOutput("rst_q_ready", 32'(slv_q_ready_o), 32'd0);
    checkOutput("rst_acc_q_valid", 32'(acc_q_valid_o), 32'd0);
    checkOutput("rst_p_valid", 32'(slv_p_valid_o), 32'd0);
    checkOutput("rst_p_id", 32'(slv_p_id_o), 32'd0);
    checkOutput("rst_p_data", slv_p_data_o, 32'd0);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("v%0d_q_ready", i), 32'(slv_q_ready_o), 32'(vecs[i].e_q_ready));
      checkOutput($sformatf("v%0d_acc_q_valid", i), 32'(acc_q_valid_o), 32'(vecs[i].e_acc_q_valid));
      if (vecs[i].e_acc_q_valid) begin
        checkOutput($sformatf("v%0d_op", i), acc_q_data_op_o, vecs[i].op);
        checkOutput($sformatf("v%0d_arga", i), acc_q_data_arga_o, vecs[i].arga);
      end
      checkOutput($sformatf("v%0d_p_valid", i), 32'(slv_p_valid_o), 32'(vecs[i].e_p_valid));
      if (vecs[i].e_p_valid) begin
        checkOutput($sformatf("v%0d_p_id", i), 32'(slv_p_id_o), 32'(vecs[i].e_p_id));
        checkOutput($sformatf("v%0d_p_data", i), slv_p_data_o, vecs[i].e_p_data);
      end
      checkOutput($sformatf("v%0d_acc_p_ready", i), 32'(acc_p_ready_o), 32'(vecs[i].e_acc_p_ready));
      checkOutput($sformatf("v%0d_outstanding", i), 32'(outstanding_o), 32'(vecs[i].e_out));
      checkOutput($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].e_err));
      tick();
    end

    $display("[TB] saturation with stalled core");
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b1, 32'h0);
      #1;
      checkOutput($sformatf("sat_push%0d_ready", i), 32'(slv_q_ready_o), 32'd1);
      tick();
    end
    drive(1'b1, 4'h5, 1'b0, 1'b1, 32'h0);
    #1;
    checkOutput("sat_full_q_ready", 32'(slv_q_ready_o), 32'd0);
    checkOutput("sat_full_acc_q_valid", 32'(acc_q_valid_o), 32'd0);
    checkOutput("sat_full_outstanding", 32'(outstanding_o), 32'd4);

    // Push and pop offered together at full: only the pop may happen.
    drive(1'b1, 4'h5, 1'b1, 1'b1, 32'hD1);
    #1;
    checkOutput("full_both_q_ready", 32'(slv_q_ready_o), 32'd0);
    checkOutput("full_both_p_valid", 32'(slv_p_valid_o), 32'd1);
    checkOutput("full_both_p_id", 32'(slv_p_id_o), 32'd1);
    tick();
    drive(1'b1, 4'h5, 1'b0, 1'b1, 32'h0);
    #1;
    checkOutput("after_pop_outstanding", 32'(outstanding_o), 32'd3);
    checkOutput("after_pop_q_ready", 32'(slv_q_ready_o), 32'd1);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0);
    #1;
    checkOutput("refill_outstanding", 32'(outstanding_o), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b1, 32'h100 + 32'(i));
      #1;
      checkOutput($sformatf("drain%0d_p_id", i), 32'(slv_p_id_o), 32'(exp_ids[i]));
      checkOutput($sformatf("drain%0d_p_data", i), slv_p_data_o, 32'h100 + 32'(i));
      tick();
    end
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0);
    #1;
    checkOutput("drained_outstanding", 32'(outstanding_o), 32'd0);

    $display("[TB] response backpressure");
    drive(1'b1, 4'h6, 1'b0, 1'b1, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0, 32'hBEEF);
      #1;
      checkOutput($sformatf("bp%0d_p_valid", i), 32'(slv_p_valid_o), 32'd1);
      checkOutput($sformatf("bp%0d_p_id", i), 32'(slv_p_id_o), 32'd6);
      checkOutput($sformatf("bp%0d_p_data", i), slv_p_data_o, 32'hBEEF);
      checkOutput($sformatf("bp%0d_acc_p_ready", i), 32'(acc_p_ready_o), 32'd0);
      checkOutput($sformatf("bp%0d_outstanding", i), 32'(outstanding_o), 32'd1);
      tick();
    end
    drive(1'b0, 4'h0, 1'b1, 1'b1, 32'hBEEF);
    #1;
    checkOutput("bp_release_acc_p_ready", 32'(acc_p_ready_o), 32'd1);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0);
    #1;
    checkOutput("bp_done_outstanding", 32'(outstanding_o), 32'd0);

    $display("[TB] orphan response");
    drive(1'b0, 4'h0, 1'b1, 1'b0, 32'hDEAD);
    #1;
    checkOutput("orphan_p_valid", 32'(slv_p_valid_o), 32'd0);
    checkOutput("orphan_acc_p_ready", 32'(acc_p_ready_o), 32'd1);
    checkOutput("orphan_err_before", 32'(err_o), 32'd0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0);
    #1;
    checkOutput("orphan_err_set", 32'(err_o), 32'd1);
    checkOutput("orphan_outstanding", 32'(outstanding_o), 32'd0);
    tick();
    tick();
    checkOutput("orphan_err_sticky", 32'(err_o), 32'd1);

    $display("[TB] mid-operation reset");
    drive(1'b1, 4'hB, 1'b0, 1'b1, 32'h0);
    tick();
    drive(1'b1, 4'hC, 1'b0, 1'b1, 32'h0);
    tick();
    drive(1'b1, 4'hD, 1'b1, 1'b1, 32'h55);
    checkOutput("pre_rst_outstanding", 32'(outstanding_o), 32'd2);
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("mid_rst_outstanding", 32'(outstanding_o), 32'd0);
    checkOutput("mid_rst_err", 32'(err_o), 32'd0);
    checkOutput("mid_rst_q_ready", 32'(slv_q_ready_o), 32'd0);
    checkOutput("mid_rst_acc_q_valid", 32'(acc_q_valid_o), 32'd0);
    checkOutput("mid_rst_p_valid", 32'(slv_p_valid_o), 32'd0);
    checkOutput("mid_rst_p_data", slv_p_data_o, 32'd0);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    drive(1'b1, 4'h7, 1'b0, 1'b1, 32'h0);
    #1;
    checkOutput("post_rst_q_ready", 32'(slv_q_ready_o), 32'd1);
    tick();
    drive(1'b0, 4'h0, 1'b1, 1'b1, 32'h77);
    #1;
    checkOutput("post_rst_outstanding", 32'(outstanding_o), 32'd1);
    checkOutput("post_rst_p_valid", 32'(slv_p_valid_o), 32'd1);
    checkOutput("post_rst_p_id", 32'(slv_p_id_o), 32'd7);
    checkOutput("post_rst_p_data", slv_p_data_o, 32'h77);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0);
    #1;
    checkOutput("post_rst_final_outstanding", 32'(outstanding_o), 32'd0);
    checkOutput("post_rst_final_err", 32'(err_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
